// File: rtl/dnn_dot_accel.sv
// Single-neuron Q16.16 dot-product accelerator: CPU configures via an Avalon-MM slave,
// operands and result move through an Avalon-MM master. Optional macro: DNN_ACCEL_PERF_COUNTER_EN.
module dnn_dot_accel #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              slave_waitrequest,
    input  logic [3:0]        slave_address,
    input  logic              slave_read,
    output logic [31:0]       slave_readdata,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    input  logic              master_waitrequest,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    input  logic [31:0]       master_readdata,
    input  logic              master_readdatavalid,
    output logic              master_write,
    output logic [31:0]       master_writedata
);

    typedef enum logic [3:0] {
        IDLE, RD_BIAS, WT_BIAS, RD_W, WT_W, RD_X, WT_X, MAC, WR_OUT
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] bias_addr, w_base, x_base, out_addr, addr_d;
    logic [LEN_W-1:0]  len, idx, idx_d, idx_inc;
    logic              relu_en;
    logic [31:0]       acc, acc_d, w_reg, w_d, x_reg, x_d, wdata_d, mac_sum;
    logic [63:0]       prod;
    logic              rd_d, wr_d, busy, cfg_we, start;

    function automatic logic [31:0] act(input logic [31:0] v, input logic relu);
        return (relu && v[31]) ? 32'h0 : v;
    endfunction

    assign busy    = (state != IDLE);
    assign cfg_we  = slave_write && !busy;
    assign start   = cfg_we && (slave_address == 4'd0);
    assign idx_inc = idx + 1'b1;
    // Sign-extended operands: the low 64 bits of the unsigned product equal the signed product.
    assign prod    = {{32{w_reg[31]}}, w_reg} * {{32{x_reg[31]}}, x_reg};
    assign mac_sum = acc + prod[47:16];

    // Master handshake: a request (read or write) holds address/data stable and is accepted
    // in the first cycle where master_waitrequest is low; read data returns later on readdatavalid.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        acc_d   = acc;
        w_d     = w_reg;
        x_d     = x_reg;
        rd_d    = master_read;
        wr_d    = master_write;
        addr_d  = master_address;
        wdata_d = master_writedata;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = RD_BIAS;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            RD_BIAS: begin
                // First cycle issues the request from the config latched on start.
                if (!master_read) begin
                    rd_d   = 1'b1;
                    addr_d = bias_addr;
                end else if (!master_waitrequest) begin
                    rd_d    = 1'b0;
                    state_d = WT_BIAS;
                end
            end
            WT_BIAS: begin
                if (master_readdatavalid) begin
                    acc_d = master_readdata;
                    if (len == '0) begin
                        state_d = WR_OUT;
                        wr_d    = 1'b1;
                        addr_d  = out_addr;
                        wdata_d = act(master_readdata, relu_en);
                    end else begin
                        state_d = RD_W;
                        rd_d    = 1'b1;
                        addr_d  = w_base + ADDR_W'({idx, 2'b00});
                    end
                end
            end
            RD_W, RD_X: begin
                if (!master_waitrequest) begin
                    rd_d    = 1'b0;
                    state_d = (state == RD_W) ? WT_W : WT_X;
                end
            end
            WT_W: begin
                if (master_readdatavalid) begin
                    w_d     = master_readdata;
                    state_d = RD_X;
                    rd_d    = 1'b1;
                    addr_d  = x_base + ADDR_W'({idx, 2'b00});
                end
            end
            WT_X: begin
                if (master_readdatavalid) begin
                    x_d     = master_readdata;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = mac_sum;
                idx_d = idx_inc;
                if (idx_inc == len) begin
                    state_d = WR_OUT;
                    wr_d    = 1'b1;
                    addr_d  = out_addr;
                    wdata_d = act(mac_sum, relu_en);
                end else begin
                    state_d = RD_W;
                    rd_d    = 1'b1;
                    addr_d  = w_base + ADDR_W'({idx_inc, 2'b00});
                end
            end
            WR_OUT: begin
                if (!master_waitrequest) begin
                    wr_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            idx              <= '0;
            acc              <= '0;
            w_reg            <= '0;
            x_reg            <= '0;
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
        end else begin
            state            <= state_d;
            idx              <= idx_d;
            acc              <= acc_d;
            w_reg            <= w_d;
            x_reg            <= x_d;
            master_read      <= rd_d;
            master_write     <= wr_d;
            master_address   <= addr_d;
            master_writedata <= wdata_d;
        end
    end

    // Config registers only change in IDLE, so they double as the latched run config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_addr <= '0;
            w_base    <= '0;
            x_base    <= '0;
            out_addr  <= '0;
            len       <= '0;
            relu_en   <= 1'b0;
        end else if (cfg_we) begin
            case (slave_address)
                4'd1:    bias_addr <= ADDR_W'(slave_writedata);
                4'd2:    w_base    <= ADDR_W'(slave_writedata);
                4'd3:    x_base    <= ADDR_W'(slave_writedata);
                4'd4:    out_addr  <= ADDR_W'(slave_writedata);
                4'd5:    len       <= LEN_W'(slave_writedata);
                4'd7:    relu_en   <= slave_writedata[0];
                default: ;
            endcase
        end
    end

`ifdef DNN_ACCEL_PERF_COUNTER_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt <= '0;
        end else if (start) begin
            perf_cnt <= '0;
        end else if (busy && (perf_cnt != 32'hFFFF_FFFF)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end
`endif

    assign slave_waitrequest = slave_read && (slave_address == 4'd0) && busy;

    always_comb begin
        slave_readdata = '0;
        if (slave_read) begin
            case (slave_address)
                4'd1:    slave_readdata = 32'(bias_addr);
                4'd2:    slave_readdata = 32'(w_base);
                4'd3:    slave_readdata = 32'(x_base);
                4'd4:    slave_readdata = 32'(out_addr);
                4'd5:    slave_readdata = 32'(len);
`ifdef DNN_ACCEL_PERF_COUNTER_EN
                4'd6:    slave_readdata = perf_cnt;
`endif
                4'd7:    slave_readdata = {31'b0, relu_en};
                default: slave_readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_dot_accel.sv
// Directed bench for dnn_dot_accel: SDRAM responder with configurable stalls and
// read latency; results checked against an expected-value queue when written back.
module tb_dnn_dot_accel;

    localparam logic [31:0] BIAS_A = 32'h0000_0010;
    localparam logic [31:0] W_A    = 32'h0000_0100;
    localparam logic [31:0] X_A    = 32'h0000_0200;
    localparam logic [31:0] OUT_A  = 32'h0000_03F0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = '0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata = '0;
    logic        master_readdatavalid = 1'b0;
    logic        master_write;
    logic [31:0] master_writedata;

    dnn_dot_accel #(.ADDR_W(32), .LEN_W(32)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] mem [0:255];
    logic [31:0] wv [0:3];
    logic [31:0] xv [0:3];

    int          cfg_wait = 0;
    int          cfg_rdv_delay = 0;
    int          stall_cnt = 0;
    logic [31:0] held_addr = '0;
    logic        rdv_pending = 1'b0;
    int          rdv_cnt = 0;
    logic [31:0] rdv_data = '0;
    int          reads_issued = 0;
    int          writes_seen = 0;
    int          wr_cyc = 0;
    int          done_cyc = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] bias, input int n, input logic relu);
        logic [31:0]        acc;
        logic signed [63:0] p;
        acc = bias;
        for (int i = 0; i < n; i++) begin
            p   = 64'($signed(wv[i])) * 64'($signed(xv[i]));
            acc = acc + p[47:16];
        end
        return (relu && acc[31]) ? 32'h0 : acc;
    endfunction

    // ---------------- SDRAM responder (drives on negedge) ----------------
    always @(negedge clk) begin
        master_readdatavalid = 1'b0;
        if (rdv_pending) begin
            if (rdv_cnt == 0) begin
                master_readdatavalid = 1'b1;
                master_readdata      = rdv_data;
                rdv_pending          = 1'b0;
            end else begin
                rdv_cnt--;
            end
        end
        if (master_read || master_write) begin
            if (stall_cnt > 0) check32("addr_stable", master_address, held_addr);
            if (stall_cnt < cfg_wait) begin
                if (stall_cnt == 0) held_addr = master_address;
                stall_cnt++;
                master_waitrequest = 1'b1;
            end else begin
                master_waitrequest = 1'b0;
                stall_cnt          = 0;
                if (master_read) begin
                    reads_issued++;
                    rdv_pending = 1'b1;
                    rdv_cnt     = cfg_rdv_delay;
                    rdv_data    = mem[master_address[9:2]];
                end else begin
                    writes_seen++;
                    wr_cyc = cyc;
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $display("FAIL unexpected_write: observed data %h expected none", master_writedata);
                    end
                    if (exp_q.size() != 0) begin
                        check32("out_data", master_writedata, exp_q.pop_front());
                        check32("out_addr", master_address, exp_addr_q.pop_front());
                    end
                end
            end
        end else begin
            master_waitrequest = 1'b0;
            stall_cnt          = 0;
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic slv_wr(input logic [3:0] a, input logic [31:0] d);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(posedge clk); #1;
        slave_write = 1'b0;
    endtask

    task automatic slv_rd(input logic [3:0] a, output logic [31:0] d, output int waits);
        slave_address = a;
        slave_read    = 1'b1;
        waits         = 0;
        #1;
        while (slave_waitrequest && waits < 3000) begin
            @(posedge clk); #1;
            waits++;
        end
        d        = slave_readdata;
        done_cyc = cyc;
        @(posedge clk); #1;
        slave_read = 1'b0;
    endtask

    task automatic configure(input logic [31:0] n, input logic relu);
        slv_wr(4'd1, BIAS_A);
        slv_wr(4'd2, W_A);
        slv_wr(4'd3, X_A);
        slv_wr(4'd4, OUT_A);
        slv_wr(4'd5, n);
        slv_wr(4'd7, {31'b0, relu});
    endtask

    task automatic load_mem(input logic [31:0] bias, input int n);
        mem[BIAS_A[9:2]] = bias;
        for (int i = 0; i < n; i++) begin
            mem[W_A[9:2] + i] = wv[i];
            mem[X_A[9:2] + i] = xv[i];
        end
    endtask

    task automatic run(input string tag, input int n, input logic [31:0] expv, input bit zero_wait);
        logic [31:0] d;
        int          waits;
        int          start_cyc;
        reads_issued = 0;
        writes_seen  = 0;
        exp_q.push_back(expv);
        exp_addr_q.push_back(OUT_A);
        start_cyc = cyc;
        slv_wr(4'd0, 32'h1);
        slv_rd(4'd0, d, waits);
        checks++;
        assert (waits < 3000) else begin
            errors++;
            $display("FAIL %s_timeout: observed %0d wait cycles expected < 3000", tag, waits);
        end
        checks++;
        assert (waits > 0) else begin
            errors++;
            $display("FAIL %s_stall: observed %0d wait cycles expected > 0", tag, waits);
        end
        check32({tag, "_done_rd"}, d, 32'h0);
        check32({tag, "_done_cyc"}, done_cyc, wr_cyc + 1);
        if (zero_wait) check32({tag, "_latency"}, wr_cyc - start_cyc, 4 + 5 * n);
        check32({tag, "_reads"}, reads_issued, 1 + 2 * n);
        check32({tag, "_writes"}, writes_seen, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] d;
        int          waits;
        logic [31:0] bias;
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 + i;

        repeat (3) @(posedge clk);
        #1;
        check32("rst_mread", master_read, 1'b0);
        check32("rst_mwrite", master_write, 1'b0);
        check32("rst_maddr", master_address, 32'h0);
        check32("rst_mwdata", master_writedata, 32'h0);
        check32("rst_swait", slave_waitrequest, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        slv_rd(4'd0, d, waits);
        check32("idle_rd0", d, 32'h0);
        check32("idle_rd0_wait", waits, 0);
        slv_wr(4'd5, 32'd7);
        slv_rd(4'd5, d, waits);
        check32("len_readback", d, 32'd7);
        slv_wr(4'd9, 32'hDEAD_BEEF);
        slv_rd(4'd9, d, waits);
        check32("unmapped_rd", d, 32'h0);
        slv_wr(4'd7, 32'h3);
        slv_rd(4'd7, d, waits);
        check32("relu_readback", d, 32'h1);
        slv_rd(4'd6, d, waits);
        check32("perf_after_reset", d, 32'h0);

        // Case 1: 0.5 + 1*3 + 2*(-1) = 1.5
        wv[0] = 32'h0001_0000; wv[1] = 32'h0002_0000;
        xv[0] = 32'h0003_0000; xv[1] = 32'hFFFF_0000;
        load_mem(32'h0000_8000, 2);
        configure(32'd2, 1'b0);
        run("t1", 2, 32'h0001_8000, 1'b1);

        // Case 2: -2 + 1*1 with and without ReLU
        wv[0] = 32'h0001_0000; xv[0] = 32'h0001_0000;
        load_mem(32'hFFFE_0000, 1);
        configure(32'd1, 1'b0);
        run("t2a", 1, 32'hFFFF_0000, 1'b1);
        configure(32'd1, 1'b1);
        run("t2b", 1, 32'h0000_0000, 1'b1);

        // Case 3: empty vector writes the bias
        load_mem(32'h1234_5678, 0);
        configure(32'd0, 1'b0);
        run("t3", 0, 32'h1234_5678, 1'b1);

        // Case 4: stalled SDRAM, same result as case 1
        wv[0] = 32'h0001_0000; wv[1] = 32'h0002_0000;
        xv[0] = 32'h0003_0000; xv[1] = 32'hFFFF_0000;
        load_mem(32'h0000_8000, 2);
        configure(32'd2, 1'b0);
        cfg_wait = 3;
        cfg_rdv_delay = 5;
        run("t4", 2, 32'h0001_8000, 1'b0);
        cfg_wait = 0;

        // Case 5: reset while waiting on the first weight of an N=4 run
        for (int i = 0; i < 4; i++) begin
            wv[i] = 32'h0001_0000;
            xv[i] = 32'h0001_0000;
        end
        load_mem(32'h0, 4);
        configure(32'd4, 1'b0);
        reads_issued = 0;
        writes_seen  = 0;
        slv_wr(4'd0, 32'h1);
        waits = 0;
        while (reads_issued < 2 && waits < 200) begin
            @(posedge clk); #1;
            waits++;
        end
        check32("t5_reach_wt_w", reads_issued, 2);
        rst_n = 1'b0;
        #1;
        check32("t5_mread", master_read, 1'b0);
        check32("t5_mwrite", master_write, 1'b0);
        slave_address = 4'd0;
        slave_read    = 1'b1;
        #1;
        check32("t5_idle_wait", slave_waitrequest, 1'b0);
        slave_address = 4'd5;
        #1;
        check32("t5_len_cleared", slave_readdata, 32'h0);
        slave_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cfg_rdv_delay = 0;
        repeat (2) @(posedge clk);
        #1;
        check32("t5_no_write", writes_seen, 0);
        wv[0] = 32'h0001_0000; wv[1] = 32'h0002_0000;
        xv[0] = 32'h0003_0000; xv[1] = 32'hFFFF_0000;
        load_mem(32'h0000_8000, 2);
        configure(32'd2, 1'b0);
        run("t5_rerun", 2, 32'h0001_8000, 1'b1);

        // Case 6: random N=3 operands, then the cycle counter
        for (int i = 0; i < 3; i++) begin
            wv[i] = $urandom_range(32'h0004_0000, 0) - 32'h0002_0000;
            xv[i] = $urandom();
        end
        bias = $urandom();
        load_mem(bias, 3);
        configure(32'd3, 1'b1);
        run("t6", 3, model(bias, 3, 1'b1), 1'b1);
        slv_rd(4'd6, d, waits);
`ifdef DNN_ACCEL_PERF_COUNTER_EN
        check32("perf_cnt", d, 32'd19);
`else
        check32("perf_cnt", d, 32'd0);
`endif
        check32("exp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
